reg_bank_arbiter: RTL and testbench

Arbitrates up to NrOfRequesters clients onto a shared bank of NrOfRegs tristate-output registers that share one data bus. Sequences each access:
- a write by pulsing that register's clock enable
- a read by releasing its output disable and capturing the shared bus
- a clear or preset by pulsing its asynchronous reset or preset line

It sits between the datapath clients and the register bank, and uses the same global Tick qualifier as the registers.

---
 rtl/reg_bank_arbiter_pkg.sv | 15 +
 rtl/reg_bank_arbiter_if.sv | 40 ++++
 rtl/reg_bank_arbiter_rr_picker.sv | 46 ++++
 rtl/reg_bank_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared opcodes and FSM encoding for the register bank arbiter.
// Optional build macro used by the arbiter: REG_ARB_FIXED_PRIO_EN.
package reg_arb_pkg;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_PRESET = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Client request/response and register-bank control bundle of the arbiter.
// slave = arbiter side, master = clients plus register bank side.
interface reg_bank_arbiter_if #(
  parameter int NrOfRequesters = 4,
  parameter int NrOfRegs       = 8,
  parameter int AddrBits       = 3,
  parameter int NrOfBits       = 8
);
  localparam int IdBits = $clog2(NrOfRequesters);

  logic [NrOfRequesters-1:0]          req;
  logic [2*NrOfRequesters-1:0]        req_op;
  logic [AddrBits*NrOfRequesters-1:0] req_addr;
  logic [NrOfBits*NrOfRequesters-1:0] req_wdata;
  logic [NrOfRequesters-1:0]          gnt;
  logic [NrOfRegs-1:0]                reg_ce;
  logic [NrOfRegs-1:0]                reg_cs;
  logic [NrOfRegs-1:0]                reg_clr;
  logic [NrOfRegs-1:0]                reg_pre;
  logic [NrOfBits-1:0]                bus_wdata;
  logic [NrOfBits-1:0]                bus_q;
  logic                               rsp_valid;
  logic [IdBits-1:0]                  rsp_id;
  logic [NrOfBits-1:0]                rsp_data;
  logic                               rsp_err;
  logic                               busy;

  modport slave (
    input  req, req_op, req_addr, req_wdata, bus_q,
    output gnt, reg_ce, reg_cs, reg_clr, reg_pre, bus_wdata,
    output rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req, req_op, req_addr, req_wdata, bus_q,
    input  gnt, reg_ce, reg_cs, reg_clr, reg_pre, bus_wdata,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/reg_bank_arbiter_rr_picker.sv
// Combinational one-hot winner selection from the request vector.
// REG_ARB_FIXED_PRIO_EN selects lowest-index-wins and ignores i_ptr.
module reg_arb_rr_picker #(
  parameter int N       = 4,
  parameter int PtrBits = 2
) (
  input  logic [N-1:0]       i_req,
  input  logic [PtrBits-1:0] i_ptr,
  output logic [N-1:0]       o_gnt
);

`ifdef REG_ARB_FIXED_PRIO_EN
  logic w_seen;

  // Lowest requesting index wins.
  always_comb begin
    o_gnt  = '0;
    w_seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      o_gnt[i] = i_req[i] & ~w_seen;
      w_seen   = w_seen | i_req[i];
    end
  end
`else
  logic [2*N-1:0] w_rot_dbl;
  logic [2*N-1:0] w_back_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_pick;
  logic           w_seen;

  // Rotate so the pointer position is bit 0, take the lowest, rotate back.
  always_comb begin
    w_rot_dbl  = {i_req, i_req} >> i_ptr;
    w_rot      = w_rot_dbl[N-1:0];
    w_pick     = '0;
    w_seen     = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_pick[i] = w_rot[i] & ~w_seen;
      w_seen    = w_seen | w_rot[i];
    end
    w_back_dbl = {w_pick, w_pick} << i_ptr;
    o_gnt      = w_back_dbl[2*N-1:N];
  end
`endif

endmodule

// File: rtl/reg_bank_arbiter.sv
// Arbitrates clients onto a shared tristate register bank, one access per two Ticks.
// Define REG_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NrOfRequesters = 4,
  parameter int NrOfRegs       = 8,
  parameter int AddrBits       = 3,
  parameter int NrOfBits       = 8
) (
  input logic                Clock,
  input logic                Reset_n,
  input logic                Tick,
  reg_bank_arbiter_if.slave  bus
);

  localparam int IdBits = $clog2(NrOfRequesters);
  localparam logic [AddrBits:0] NREGS_W = (AddrBits+1)'(NrOfRegs);

  state_e                    r_state, w_state;
  logic [1:0]                r_op, w_op;
  logic [AddrBits-1:0]       r_addr, w_addr;
  logic [IdBits-1:0]         r_id, w_id;
  logic [NrOfRequesters-1:0] r_gnt, w_gnt;
  logic [NrOfRegs-1:0]       r_ce, w_ce, r_cs, w_cs, r_clr, w_clr, r_pre, w_pre;
  logic [NrOfBits-1:0]       r_wdata, w_wdata, r_rsp_data, w_rsp_data;
  logic                      r_rsp_valid, w_rsp_valid, r_rsp_err, w_rsp_err;
  logic [IdBits-1:0]         r_rsp_id, w_rsp_id;
  logic                      r_busy, w_busy;

  logic [NrOfRequesters-1:0] w_win;
  logic [IdBits-1:0]         w_win_id, w_ptr;
  logic [1:0]                w_sel_op;
  logic [AddrBits-1:0]       w_sel_addr;
  logic [NrOfBits-1:0]       w_sel_wdata;
  logic [NrOfRegs-1:0]       w_sel_dec;
  logic                      w_sel_ok, w_cur_ok, w_take;

  reg_arb_rr_picker #(.N(NrOfRequesters), .PtrBits(IdBits)) u_picker (
    .i_req (bus.req),
    .i_ptr (w_ptr),
    .o_gnt (w_win)
  );

  // Mux the winner's op, address and data out of the flattened request buses.
  always_comb begin
    w_win_id    = '0;
    w_sel_op    = 2'b00;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NrOfRequesters; i++) begin
      w_win_id    = w_win_id    | (w_win[i] ? IdBits'(i) : '0);
      w_sel_op    = w_sel_op    | (bus.req_op[2*i +: 2] & {2{w_win[i]}});
      w_sel_addr  = w_sel_addr  | (bus.req_addr[AddrBits*i +: AddrBits] & {AddrBits{w_win[i]}});
      w_sel_wdata = w_sel_wdata | (bus.req_wdata[NrOfBits*i +: NrOfBits] & {NrOfBits{w_win[i]}});
    end
  end

  assign w_sel_ok  = ({1'b0, w_sel_addr} < NREGS_W);
  assign w_cur_ok  = ({1'b0, r_addr} < NREGS_W);
  assign w_sel_dec = w_sel_ok ? ({{(NrOfRegs-1){1'b0}}, 1'b1} << w_sel_addr) : '0;
  assign w_take    = (r_state == IDLE) && Tick && (|bus.req);

`ifdef REG_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IdBits-1:0] r_ptr;

  // Round-robin pointer moves to winner+1 on every grant.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= (w_win_id == IdBits'(NrOfRequesters-1)) ? '0 : w_win_id + 1'b1;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // Next state and next registered outputs; gnt and rsp_valid are single-cycle pulses.
  always_comb begin
    w_state     = r_state;
    w_op        = r_op;
    w_addr      = r_addr;
    w_id        = r_id;
    w_gnt       = '0;
    w_ce        = r_ce;
    w_cs        = r_cs;
    w_clr       = r_clr;
    w_pre       = r_pre;
    w_wdata     = r_wdata;
    w_rsp_valid = 1'b0;
    w_rsp_id    = r_rsp_id;
    w_rsp_data  = r_rsp_data;
    w_rsp_err   = r_rsp_err;
    w_busy      = r_busy;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_state = EXEC;
          w_op    = w_sel_op;
          w_addr  = w_sel_addr;
          w_id    = w_win_id;
          w_gnt   = w_win;
          w_busy  = 1'b1;
          w_ce    = (w_sel_op == OP_WRITE)  ? w_sel_dec  : '0;
          w_cs    = (w_sel_op == OP_READ)   ? ~w_sel_dec : '1;
          w_clr   = (w_sel_op == OP_CLEAR)  ? w_sel_dec  : '0;
          w_pre   = (w_sel_op == OP_PRESET) ? w_sel_dec  : '0;
          w_wdata = (w_sel_op == OP_WRITE)  ? w_sel_wdata : r_wdata;
        end else begin
          w_state = IDLE;
        end
      end
      EXEC: begin
        if (Tick) begin
          w_state = IDLE;
          w_busy  = 1'b0;
          w_ce    = '0;
          w_cs    = '1;
          w_clr   = '0;
          w_pre   = '0;
          if (r_op == OP_READ) begin
            w_rsp_valid = 1'b1;
            w_rsp_id    = r_id;
            w_rsp_data  = w_cur_ok ? bus.bus_q : '0;
            w_rsp_err   = ~w_cur_ok;
          end else begin
            w_rsp_valid = 1'b0;
          end
        end else begin
          w_state = EXEC;
        end
      end
      default: begin
        w_state = IDLE;
        w_busy  = 1'b0;
        w_ce    = '0;
        w_cs    = '1;
        w_clr   = '0;
        w_pre   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_op        <= OP_WRITE;
      r_addr      <= '0;
      r_id        <= '0;
      r_gnt       <= '0;
      r_ce        <= '0;
      r_cs        <= '1;
      r_clr       <= '0;
      r_pre       <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_op        <= w_op;
      r_addr      <= w_addr;
      r_id        <= w_id;
      r_gnt       <= w_gnt;
      r_ce        <= w_ce;
      r_cs        <= w_cs;
      r_clr       <= w_clr;
      r_pre       <= w_pre;
      r_wdata     <= w_wdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_id    <= w_rsp_id;
      r_rsp_data  <= w_rsp_data;
      r_rsp_err   <= w_rsp_err;
      r_busy      <= w_busy;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.reg_ce    = r_ce;
  assign bus.reg_cs    = r_cs;
  assign bus.reg_clr   = r_clr;
  assign bus.reg_pre   = r_pre;
  assign bus.bus_wdata = r_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a behavioural 8x8 register bank on bus_q.
module tb_reg_bank_arbiter;

  logic clk;
  logic rst_n;
  logic tick;
  int   n_cmp;
  int   n_err;
  logic [7:0] mem [8];

  reg_bank_arbiter_if #(.NrOfRequesters(4), .NrOfRegs(8), .AddrBits(4), .NrOfBits(8)) bus ();

  reg_bank_arbiter #(.NrOfRequesters(4), .NrOfRegs(8), .AddrBits(4), .NrOfBits(8)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .Tick    (tick),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model: Tick-qualified write, clear/preset lines, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (bus.reg_clr[i]) mem[i] <= 8'h00;
        else if (bus.reg_pre[i]) mem[i] <= 8'hFF;
        else if (tick && bus.reg_ce[i]) mem[i] <= bus.bus_wdata;
      end
    end
  end

  // Tristate bus: only the register with output enabled drives bus_q.
  always_comb begin
    bus.bus_q = 8'h00;
    for (int i = 0; i < 8; i++) if (!bus.reg_cs[i]) bus.bus_q = mem[i];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
    bus.req[c]             = 1'b1;
    bus.req_op[2*c +: 2]   = op;
    bus.req_addr[4*c +: 4] = a;
    bus.req_wdata[8*c +: 8] = d;
  endtask

  // Request from one client, advance into EXEC and drop the request.
  task automatic issue(input int c, input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
    set_req(c, op, a, d);
    step();
    bus.req = 4'b0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick  = 1'b1;
    bus.req = 4'b0000; bus.req_op = 8'h00; bus.req_addr = 16'h0000; bus.req_wdata = 32'h0;
    step(); step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus.reg_cs !== 8'hFF) begin n_err++; $display("FAIL rst_cs: got %h want ff", bus.reg_cs); end
    n_cmp++; if ({bus.reg_ce, bus.reg_clr, bus.reg_pre} !== 24'h0) begin n_err++; $display("FAIL rst_lines: got %h want 0", {bus.reg_ce, bus.reg_clr, bus.reg_pre}); end
    n_cmp++; if ({bus.gnt, bus.busy, bus.rsp_valid, bus.rsp_err} !== 7'h0) begin n_err++; $display("FAIL rst_ctl: got %b want 0", {bus.gnt, bus.busy, bus.rsp_valid, bus.rsp_err}); end
    n_cmp++; if ({bus.bus_wdata, bus.rsp_data, bus.rsp_id} !== 18'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", {bus.bus_wdata, bus.rsp_data, bus.rsp_id}); end
  endtask

  task automatic test_rr();
    logic [3:0] exp [6];
`ifdef REG_ARB_FIXED_PRIO_EN
    exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
`endif
    set_req(0, 2'b00, 4'd0, 8'h00);
    set_req(1, 2'b00, 4'd0, 8'h00);
    set_req(3, 2'b00, 4'd0, 8'h00);
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++; if (bus.gnt !== exp[k]) begin n_err++; $display("FAIL rr_gnt%0d: got %b want %b", k, bus.gnt, exp[k]); end
      step();
      n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL rr_gap%0d: got %b want 0000", k, bus.gnt); end
    end
    bus.req = 4'b0000;
    step(); step();
  endtask

  task automatic test_write_read();
    issue(1, 2'b00, 4'd3, 8'hA5);
    n_cmp++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL wr_gnt: got %b want 0010", bus.gnt); end
    n_cmp++; if (bus.reg_ce !== 8'b0000_1000) begin n_err++; $display("FAIL wr_ce: got %b want 00001000", bus.reg_ce); end
    n_cmp++; if (bus.bus_wdata !== 8'hA5) begin n_err++; $display("FAIL wr_data: got %h want a5", bus.bus_wdata); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", bus.busy); end
    step();
    n_cmp++; if ({bus.gnt, bus.reg_ce, bus.busy} !== 13'h0) begin n_err++; $display("FAIL wr_idle: got %h want 0", {bus.gnt, bus.reg_ce, bus.busy}); end
    issue(2, 2'b01, 4'd3, 8'h00);
    n_cmp++; if (bus.reg_cs !== 8'b1111_0111) begin n_err++; $display("FAIL rd_cs: got %b want 11110111", bus.reg_cs); end
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL rd_gnt: got %b want 0100", bus.gnt); end
    step();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err} !== 4'b1100) begin n_err++; $display("FAIL rd_rsp: got %b want 1100", {bus.rsp_valid, bus.rsp_id, bus.rsp_err}); end
    n_cmp++; if (bus.rsp_data !== 8'hA5) begin n_err++; $display("FAIL rd_data: got %h want a5", bus.rsp_data); end
    n_cmp++; if (bus.reg_cs !== 8'hFF) begin n_err++; $display("FAIL rd_cs_idle: got %h want ff", bus.reg_cs); end
    step();
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_pulse: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_preset_clear();
    issue(0, 2'b11, 4'd5, 8'h00);
    n_cmp++; if ({bus.reg_pre, bus.reg_clr} !== 16'b0010_0000_0000_0000) begin n_err++; $display("FAIL pre_lines: got %b want 0010000000000000", {bus.reg_pre, bus.reg_clr}); end
    step();
    n_cmp++; if (bus.reg_pre !== 8'h00) begin n_err++; $display("FAIL pre_drop: got %b want 0", bus.reg_pre); end
    issue(0, 2'b01, 4'd5, 8'h00);
    step();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== 9'h1FF) begin n_err++; $display("FAIL pre_read: got %h want 1ff", {bus.rsp_valid, bus.rsp_data}); end
    issue(0, 2'b10, 4'd5, 8'h00);
    n_cmp++; if ({bus.reg_clr, bus.reg_pre} !== 16'b0010_0000_0000_0000) begin n_err++; $display("FAIL clr_lines: got %b want 0010000000000000", {bus.reg_clr, bus.reg_pre}); end
    step();
    n_cmp++; if (bus.reg_clr !== 8'h00) begin n_err++; $display("FAIL clr_drop: got %b want 0", bus.reg_clr); end
    issue(0, 2'b01, 4'd5, 8'h00);
    step();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== 9'h100) begin n_err++; $display("FAIL clr_read: got %h want 100", {bus.rsp_valid, bus.rsp_data}); end
  endtask

  task automatic test_bad_addr();
    issue(3, 2'b01, 4'd9, 8'h00);
    n_cmp++; if (bus.reg_cs !== 8'hFF) begin n_err++; $display("FAIL bad_cs: got %b want 11111111", bus.reg_cs); end
    n_cmp++; if ({bus.gnt, bus.busy} !== 5'b10001) begin n_err++; $display("FAIL bad_gnt: got %b want 10001", {bus.gnt, bus.busy}); end
    step();
    n_cmp++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err} !== 4'b1111) begin n_err++; $display("FAIL bad_rsp: got %b want 1111", {bus.rsp_valid, bus.rsp_id, bus.rsp_err}); end
    n_cmp++; if (bus.rsp_data !== 8'h00) begin n_err++; $display("FAIL bad_data: got %h want 00", bus.rsp_data); end
  endtask

  task automatic test_stretch();
    int cs_low;
    int rsp_cnt;
    cs_low  = 0;
    rsp_cnt = 0;
    issue(0, 2'b01, 4'd3, 8'h00);
    tick = 1'b0;
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL st_gnt: got %b want 0001", bus.gnt); end
    for (int k = 1; k <= 6; k++) begin
      if (bus.reg_cs == 8'b1111_0111) cs_low++;
      if (bus.rsp_valid) rsp_cnt++;
      if (k == 2) begin
        n_cmp++; if ({bus.gnt, bus.busy} !== 5'b00001) begin n_err++; $display("FAIL st_hold: got %b want 00001", {bus.gnt, bus.busy}); end
      end
      if (k == 4) tick = 1'b1;
      if (k == 5) begin
        n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== 9'h1A5) begin n_err++; $display("FAIL st_rsp: got %h want 1a5", {bus.rsp_valid, bus.rsp_data}); end
      end
      step();
    end
    n_cmp++; if (cs_low !== 4) begin n_err++; $display("FAIL st_cs_cycles: got %0d want 4", cs_low); end
    n_cmp++; if (rsp_cnt !== 1) begin n_err++; $display("FAIL st_rsp_count: got %0d want 1", rsp_cnt); end
  endtask

  task automatic test_reset_mid();
    issue(1, 2'b01, 4'd3, 8'h00);
    n_cmp++; if (bus.reg_cs !== 8'b1111_0111) begin n_err++; $display("FAIL rm_cs: got %b want 11110111", bus.reg_cs); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.reg_cs, bus.busy, bus.gnt} !== 13'b1111_1111_0_0000) begin n_err++; $display("FAIL rm_async: got %b want 1111111100000", {bus.reg_cs, bus.busy, bus.gnt}); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rm_rsp%0d: got %b want 0", k, bus.rsp_valid); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_rr();
    test_write_read();
    test_preset_clear();
    test_bad_addr();
    test_stretch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
